// File: rtl/hs_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin 4-phase handshake arbiter.
package hs_pkg;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_REQ  = 2'd1,
    A_ACK  = 2'd2,
    A_REL  = 2'd3
  } arb_state_t;

  localparam int DEFAULT_DATA_W = 8;

  // A single master still needs a 1-bit grant index.
  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hs_rr_arbiter_if.sv
// Bundle of the upstream (per-master) and downstream handshake signals of the arbiter.
interface hs_rr_arbiter_if
  import hs_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int CNT_W       = 16
);
  localparam int GID_W = gid_width(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS*DATA_W-1:0] m_data;
  logic [NUM_MASTERS-1:0]        m_ack;
  logic                          s_req;
  logic [DATA_W-1:0]             s_data;
  logic                          s_ack;
  logic [GID_W-1:0]              grant_id;
  logic                          busy;
  logic [CNT_W-1:0]              xfer_count;

  // The arbiter itself sits on the slave side of the masters.
  modport slave (
    input  m_req, m_data, s_ack,
    output m_ack, s_req, s_data, grant_id, busy, xfer_count
  );

  modport master (
    output m_req, m_data, s_ack,
    input  m_ack, s_req, s_data, grant_id, busy, xfer_count
  );

endinterface

// File: rtl/hs_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick
  import hs_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  localparam logic [W:0] N_W = (W+1)'(N);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [W:0]     pos;
  logic           found;

  // Rotating a doubled copy puts request[ptr] at bit 0.
  assign doubled = {req, req};
  assign rotated = N'(doubled >> ptr);
  assign any     = |req;

  always_comb begin
    found = 1'b0;
    pos   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        pos   = {1'b0, ptr} + (W+1)'(i);
        if (pos >= N_W) pos = pos - N_W;
        idx   = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one registered 4-phase req/ack byte channel among several masters.
module hs_rr_arbiter
  import hs_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int CNT_W       = 16
) (
  input logic           clk,
  input logic           rst_n,
  hs_rr_arbiter_if.slave bus
);

  localparam int GID_W = gid_width(NUM_MASTERS);

  arb_state_t             state_q, state_d;
  logic [GID_W-1:0]       ptr_q, ptr_d;
  logic [GID_W-1:0]       grant_q, grant_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   s_req_q, s_req_d;
  logic [NUM_MASTERS-1:0] m_ack_q, m_ack_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   pick_any;
  logic [GID_W-1:0]       pick_idx;
  logic [DATA_W-1:0]      data_sel;

  rr_pick #(.N(NUM_MASTERS), .W(GID_W)) u_pick (
    .req (bus.m_req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_idx == GID_W'(i)) data_sel = bus.m_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    s_req_d = s_req_q;
    m_ack_d = m_ack_q;
    busy_d  = busy_q;
    count_d = count_q;
    case (state_q)
      A_IDLE: begin
        // A still-high s_ack belongs to an older transfer, so nothing is granted until it clears.
        if (!bus.s_ack && pick_any) begin
          grant_d = pick_idx;
          data_d  = data_sel;
          s_req_d = 1'b1;
          busy_d  = 1'b1;
          state_d = A_REQ;
        end
      end
      A_REQ: begin
        if (bus.s_ack) begin
          m_ack_d = NUM_MASTERS'(1) << grant_q;
          state_d = A_ACK;
        end
      end
      A_ACK: begin
        if (!bus.m_req[grant_q]) begin
          s_req_d = 1'b0;
          state_d = A_REL;
        end
      end
      A_REL: begin
        if (!bus.s_ack) begin
          m_ack_d = '0;
          ptr_d   = (grant_q == GID_W'(NUM_MASTERS-1)) ? '0 : grant_q + 1'b1;
          count_d = count_q + 1'b1;
          busy_d  = 1'b0;
          state_d = A_IDLE;
        end
      end
      default: begin
        s_req_d = 1'b0;
        m_ack_d = '0;
        busy_d  = 1'b0;
        state_d = A_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= A_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      s_req_q <= 1'b0;
      m_ack_q <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      s_req_q <= s_req_d;
      m_ack_q <= m_ack_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign bus.m_ack      = m_ack_q;
  assign bus.s_req      = s_req_q;
  assign bus.s_data     = data_q;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = busy_q;
  assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Scoreboard bench for hs_rr_arbiter: directed master/slave traffic, monitor checks every grant.
module tb_hs_rr_arbiter;

  localparam int NM = 4;

  typedef struct packed {
    logic [1:0]  gid;
    logic [7:0]  data;
    logic [15:0] cnt;
    logic        chk_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 0;
  int   credits[NM];
  int   mst_st[NM];
  int   slave_st = 0;
  int   ack_cnt = 0;
  int   ack_delay = 3;
  bit   slave_en = 1;
  logic prev_s_req = 0, prev_s_ack = 0, prev_busy = 0;
  logic [NM-1:0] prev_m_ack = '0;

  hs_rr_arbiter_if #(.NUM_MASTERS(NM), .DATA_W(8), .CNT_W(16)) bus ();

  hs_rr_arbiter #(.NUM_MASTERS(NM), .DATA_W(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] gid, input logic [15:0] cnt, input logic chk);
    exp_t e;
    e.gid     = gid;
    e.data    = 8'hA0 + {6'd0, gid};
    e.cnt     = cnt;
    e.chk_cnt = chk;
    exp_q.push_back(e);
  endtask

  function automatic bit all_done();
    bit d = !bus.busy && (exp_q.size() == 0);
    for (int i = 0; i < NM; i++) if (credits[i] != 0 || mst_st[i] != 0) d = 0;
    return d;
  endfunction

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!all_done() && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(all_done()), 32'd1);
  endtask

  task automatic wait_ack(input int idx, input int budget, input string name);
    int n = 0;
    while (!bus.m_ack[idx] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.m_ack[idx]), 32'd1);
  endtask

  task automatic do_reset(input bit stale);
    rst_n = 1'b0;
    bus.s_ack = stale;
    slave_en = !stale;
    slave_st = 0;
    bus.m_req = '0;
    for (int i = 0; i < NM; i++) begin
      credits[i] = 0;
      mst_st[i] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Master model: each credit is one full 4-phase transfer, re-requesting right after release.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NM; i++) begin
      case (mst_st[i])
        1: if (bus.m_ack[i]) begin
          bus.m_req[i] = 1'b0;
          mst_st[i] = 2;
        end
        2: if (!bus.m_ack[i]) begin
          credits[i]--;
          mst_st[i] = 0;
          if (credits[i] > 0) begin
            bus.m_req[i] = 1'b1;
            mst_st[i] = 1;
          end
        end
        default: if (credits[i] > 0) begin
          bus.m_req[i] = 1'b1;
          mst_st[i] = 1;
        end
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (slave_en) begin
      case (slave_st)
        1: begin
          ack_cnt++;
          if (ack_cnt >= ack_delay) begin
            bus.s_ack = 1'b1;
            slave_st = 2;
          end
        end
        2: if (!bus.s_req) begin
          bus.s_ack = 1'b0;
          slave_st = 0;
        end
        default: if (bus.s_req) begin
          ack_cnt = 0;
          slave_st = 1;
        end
      endcase
    end
  end

  // Monitor: pops the expected transfer on every s_req rise and follows it to completion.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      have_cur = 0;
      prev_s_req = 0;
      prev_s_ack = 0;
      prev_busy = 0;
      prev_m_ack = '0;
    end else begin
      if (bus.s_req && !prev_s_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(bus.grant_id), 32'hFFFF_FFFF);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          check("grant_id", 32'(bus.grant_id), 32'(cur.gid));
          check("grant_busy", 32'(bus.busy), 32'd1);
        end
      end
      if (bus.s_req && have_cur) begin
        check("s_data", 32'(bus.s_data), 32'(cur.data));
        check("other_m_ack", 32'(bus.m_ack & ~(4'd1 << cur.gid)), 32'd0);
      end
      if (bus.m_ack != '0 && prev_m_ack == '0 && have_cur) begin
        check("m_ack_onehot", 32'(bus.m_ack), 32'(4'd1 << cur.gid));
        check("m_ack_rise_after_s_ack", 32'(prev_s_ack), 32'd1);
      end
      if (bus.m_ack == '0 && prev_m_ack != '0)
        check("m_ack_fall_after_s_ack", 32'(prev_s_ack), 32'd0);
      if (!bus.busy && prev_busy && have_cur && cur.chk_cnt) begin
        check("xfer_count", 32'(bus.xfer_count), 32'(cur.cnt));
        check("done_grant_id", 32'(bus.grant_id), 32'(cur.gid));
      end
      prev_s_req = bus.s_req;
      prev_s_ack = bus.s_ack;
      prev_busy  = bus.busy;
      prev_m_ack = bus.m_ack;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.m_req = '0;
    bus.s_ack = 1'b0;
    bus.m_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < NM; i++) begin
      credits[i] = 0;
      mst_st[i] = 0;
    end
    repeat (2) @(negedge clk);
    check("rst_s_req", 32'(bus.s_req), 32'd0);
    check("rst_m_ack", 32'(bus.m_ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_s_data", 32'(bus.s_data), 32'd0);
    check("rst_xfer_count", 32'(bus.xfer_count), 32'd0);
    rst_n = 1'b1;

    // Single transfer, driven by hand to check the one-cycle relay latency.
    push_exp(2'd0, 16'd1, 1'b1);
    @(posedge clk);
    #1 bus.m_req[0] = 1'b1;
    @(negedge clk);
    check("req_latency_early", 32'(bus.s_req), 32'd0);
    @(negedge clk);
    check("req_latency", 32'(bus.s_req), 32'd1);
    wait_ack(0, 30, "single_ack_timeout");
    @(posedge clk);
    #1 bus.m_req[0] = 1'b0;
    wait_done(50, "single_done");
    check("single_count", 32'(bus.xfer_count), 32'd1);

    // Contention: all four request together, master 0 twice.
    do_reset(1'b0);
    push_exp(2'd0, 16'd1, 1'b1);
    push_exp(2'd1, 16'd2, 1'b1);
    push_exp(2'd2, 16'd3, 1'b1);
    push_exp(2'd3, 16'd4, 1'b1);
    push_exp(2'd0, 16'd5, 1'b1);
    credits[0] = 2;
    credits[1] = 1;
    credits[2] = 1;
    credits[3] = 1;
    wait_done(300, "contention_done");

    // Pointer: after master 2 is served, 1 and 3 together resolve to 3 then 1.
    do_reset(1'b0);
    push_exp(2'd2, 16'd1, 1'b1);
    credits[2] = 1;
    wait_done(60, "ptr_first_done");
    push_exp(2'd3, 16'd2, 1'b1);
    push_exp(2'd1, 16'd3, 1'b1);
    credits[1] = 1;
    credits[3] = 1;
    wait_done(120, "ptr_pair_done");

    // Stale ack held through reset release blocks the grant.
    do_reset(1'b1);
    credits[0] = 1;
    push_exp(2'd0, 16'd1, 1'b1);
    repeat (5) @(negedge clk);
    check("stale_ack_hold", 32'(bus.s_req), 32'd0);
    check("stale_ack_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    bus.s_ack = 1'b0;
    slave_en = 1;
    @(negedge clk);
    check("stale_ack_latency", 32'(bus.s_req), 32'd0);
    @(negedge clk);
    check("stale_ack_release", 32'(bus.s_req), 32'd1);
    wait_done(60, "stale_done");

    // Reset in A_ACK clears outputs asynchronously; the master's retry completes.
    push_exp(2'd0, 16'd0, 1'b0);
    push_exp(2'd0, 16'd1, 1'b1);
    credits[0] = 2;
    wait_ack(0, 40, "abort_ack_timeout");
    #1 rst_n = 1'b0;
    #1;
    check("abort_m_ack", 32'(bus.m_ack), 32'd0);
    check("abort_s_req", 32'(bus.s_req), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_count", 32'(bus.xfer_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(80, "abort_retry_done");
    check("abort_retry_count", 32'(bus.xfer_count), 32'd1);

    // Slow slave plus counter wrap from a forced preload.
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    check("count_preload", 32'(bus.xfer_count), 32'hFFFF);
    ack_delay = 20;
    push_exp(2'd1, 16'd0, 1'b1);
    credits[1] = 1;
    wait_done(100, "slow_done");
    check("count_wrap", 32'(bus.xfer_count), 32'd0);
    ack_delay = 3;

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
